// File: rtl/kmap_sweep_ctrl.sv
// rtl/kmap_sweep_ctrl.sv - exhaustive 4-input sweep, truth-table capture and masked compare
// Optional KMAP_SWEEP_GRAY_EN: visit minterms in Gray order instead of binary order.
module kmap_sweep_ctrl #(
  parameter int unsigned SETTLE    = 1,
  parameter logic [15:0] EXP_TABLE = 16'hDD0C,
  parameter logic [15:0] CARE_MASK = 16'hDDEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_out,
  output logic [4:0]  mism_cnt,
  output logic [3:0]  first_mism,
  output logic        mism_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  // Maps a sweep position to the minterm visited at that position.
  function automatic logic [3:0] order_idx(input logic [3:0] s);
`ifdef KMAP_SWEEP_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  step_q, step_d;
  logic [3:0]  term_q, term_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  mcnt_q, mcnt_d;
  logic [3:0]  first_q, first_d;
  logic        mvalid_q, mvalid_d;
  logic        pass_q, pass_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      step_q   <= 4'd0;
      term_q   <= 4'd0;
      table_q  <= 16'd0;
      mcnt_q   <= 5'd0;
      first_q  <= 4'd0;
      mvalid_q <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      term_q   <= term_d;
      table_q  <= table_d;
      mcnt_q   <= mcnt_d;
      first_q  <= first_d;
      mvalid_q <= mvalid_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    term_d   = term_q;
    table_d  = table_q;
    mcnt_d   = mcnt_q;
    first_d  = first_q;
    mvalid_d = mvalid_q;
    pass_d   = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          table_d  = 16'd0;
          mcnt_d   = 5'd0;
          mvalid_d = 1'b0;
          pass_d   = 1'b0;
          step_d   = 4'd0;
          term_d   = order_idx(4'd0);
          cnt_d    = RELOAD;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
          step_d  = 4'd0;
          term_d  = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
          step_d  = 4'd0;
          term_d  = 4'd0;
        end else begin
          table_d[term_q] = f_in;
          if (CARE_MASK[term_q] && (f_in != EXP_TABLE[term_q])) begin
            mcnt_d = mcnt_q + 5'd1;
            if (!mvalid_q) begin
              first_d  = term_q;
              mvalid_d = 1'b1;
            end
          end
          // Settle pass here so it is already valid during the done pulse.
          if (step_q == 4'd15) begin
            pass_d  = (mcnt_d == 5'd0);
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 4'd1;
            term_d  = order_idx(step_q + 4'd1);
            cnt_d   = RELOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign {a, b, c, d} = term_q;
  assign busy         = (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign done         = (state_q == S_DONE);
  assign pass         = pass_q;
  assign table_out    = table_q;
  assign mism_cnt     = mcnt_q;
  assign first_mism   = first_q;
  assign mism_valid   = mvalid_q;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// tb/tb_kmap_sweep_ctrl.sv - directed self-checking bench for kmap_sweep_ctrl
module tb_kmap_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start1, abort1, start3, abort3;
  logic [15:0] model_tbl;
  logic        a1, b1, c1, d1, busy1, done1, pass1, mvalid1;
  logic        a3, b3, c3, d3, busy3, done3, pass3, mvalid3;
  logic [15:0] table1, table3;
  logic [4:0]  mcnt1, mcnt3;
  logic [3:0]  first1, first3;
  logic [3:0]  term1, term3;
  logic        f_in1, f_in3;

  assign term1 = {a1, b1, c1, d1};
  assign term3 = {a3, b3, c3, d3};
  assign f_in1 = model_tbl[term1];
  assign f_in3 = model_tbl[term3];

  kmap_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .f_in(f_in1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .table_out(table1), .mism_cnt(mcnt1), .first_mism(first1), .mism_valid(mvalid1)
  );

  kmap_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort3), .f_in(f_in3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3), .pass(pass3),
    .table_out(table3), .mism_cnt(mcnt3), .first_mism(first3), .mism_valid(mvalid3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start on dut1 and returns the cycle index (1 = first cycle after accept) of done.
  task automatic sweep1(output int cyc);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc, run, bad, runs, ndone;
  logic [3:0] prev;

  initial begin
    reset = 1'b1; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    model_tbl = 16'hDD0C;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_abcd", term1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_table", table1, 0);
    chk("rst_mvalid", mvalid1, 0);
    reset = 1'b0;

    // Correct function, SETTLE=1
    sweep1(cyc);
    chk("clean_latency", cyc, 33);
    chk("clean_pass", pass1, 1);
    chk("clean_mcnt", mcnt1, 0);
    chk("clean_mvalid", mvalid1, 0);
    chk("clean_table", table1, 16'hDD0C);
    @(negedge clk);
    chk("done_one_cycle", done1, 0);
    chk("pass_held", pass1, 1);
    chk("abcd_hold_last", term1, 4'd15 ^ ((term1 == 4'd8) ? 4'd7 : 4'd0));

    // Don't-care immunity
    model_tbl = 16'hFF1C;
    sweep1(cyc);
    chk("dc_table", table1, 16'hFF1C);
    chk("dc_pass", pass1, 1);
    chk("dc_mcnt", mcnt1, 0);

    // Faults at minterms 5 and 10
    model_tbl = 16'hD92C;
    sweep1(cyc);
    chk("flt_latency", cyc, 33);
    chk("flt_table", table1, 16'hD92C);
    chk("flt_mcnt", mcnt1, 2);
    chk("flt_first", first1, 5);
    chk("flt_mvalid", mvalid1, 1);
    chk("flt_pass", pass1, 0);

    // Abort when a..d first reaches 7
    model_tbl = 16'hDD0C;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (term1 != 4'd7 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach7", term1, 7);
    abort1 = 1'b1;
    @(posedge clk);
    #1;
    abort1 = 1'b0;
    chk("abort_busy", busy1, 0);
    chk("abort_abcd", term1, 0);
    chk("abort_done", done1, 0);
    chk("abort_pass", pass1, 0);
    chk("abort_partial_table", table1, 16'h000C);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1 || busy1) ndone++;
    end
    chk("abort_stays_idle", ndone, 0);
    sweep1(cyc);
    chk("post_abort_latency", cyc, 33);
    chk("post_abort_pass", pass1, 1);
    chk("post_abort_table", table1, 16'hDD0C);

    // SETTLE=3 with a start pulsed mid-sweep
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    cyc = 1; prev = term3; run = 1; bad = 0; runs = 0;
    while (!done3 && cyc < 400) begin
      start3 = (cyc == 21);
      @(negedge clk);
      cyc++;
      if (term3 != prev) begin
        if (run != 4) bad++;
        runs++;
        run = 1;
        prev = term3;
      end else begin
        run++;
      end
    end
    start3 = 1'b0;
    chk("s3_latency", cyc, 65);
    chk("s3_runs", runs, 15);
    chk("s3_run_len_bad", bad, 0);
    chk("s3_pass", pass3, 1);
    chk("s3_table", table3, 16'hDD0C);

    // Asynchronous reset during WAIT
    model_tbl = 16'hD92C;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (term1 != 4'd5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_busy_before", busy1, 1);
    chk("rst_mid_table_before", table1, 16'h000C);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", busy1, 0);
    chk("rst_mid_abcd", term1, 0);
    chk("rst_mid_table", table1, 0);
    chk("rst_mid_first", first1, 0);
    chk("rst_mid_mcnt", mcnt1, 0);
    chk("rst_mid_done", done1, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
